// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage
//   Load/store unit for the MEM stage. It takes one entry from EX/MEM and, for an
//   aligned load or store, drives the data-memory port for exactly one cycle.
//   Load data is shifted down to the access offset, then sign- or zero-extended.
//   The result is held for WB under a valid/ready handshake. Non-memory entries
//   and misaligned accesses skip the memory cycle and pass the ALU result through.
//
// Ports
//   clock, reset              : clock, asynchronous active-high reset
//   in_valid / in_ready       : EX/MEM entry handshake
//   in_is_load, in_is_store,
//   in_funct3, in_addr,
//   in_wdata, in_rd, in_rd_wen: entry fields
//   mem_raddr .. mem_write_en : request to the data-memory block
//   mem_rdata                 : combinational read data, valid while mem_read_en=1
//   out_valid / out_ready     : WB handshake
//   out_result, out_rd,
//   out_rd_wen, out_misalign  : WB entry fields
//
// Handshake: a transfer happens on a rising clock edge where valid and ready
// are both 1. The producer holds valid and its payload until that transfer.
// The consumer may drive ready regardless of valid. in_ready is 1 only in IDLE,
// so there is never back-to-back acceptance.
module lsu_mem_stage #(
    parameter int XLEN = 64,
    parameter int RD_W = 5
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_is_load,
    input  logic            in_is_store,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic [RD_W-1:0] in_rd,
    input  logic            in_rd_wen,
    output logic [XLEN-1:0] mem_raddr,
    output logic            mem_read_en,
    output logic [XLEN-1:0] mem_waddr,
    output logic [XLEN-1:0] mem_wdata,
    output logic [7:0]      mem_wmask,
    output logic            mem_write_en,
    input  logic [XLEN-1:0] mem_rdata,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [RD_W-1:0] out_rd,
    output logic            out_rd_wen,
    output logic            out_misalign
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            load_q, load_d;
    logic            store_q, store_d;
    logic [2:0]      funct3_q, funct3_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [RD_W-1:0] rd_q, rd_d;
    logic            rd_wen_q, rd_wen_d;
    logic [XLEN-1:0] out_result_q, out_result_d;
    logic [RD_W-1:0] out_rd_q, out_rd_d;
    logic            out_rd_wen_q, out_rd_wen_d;
    logic            out_misalign_q, out_misalign_d;

    // Alignment of the incoming entry. Size comes from funct3[1:0] for loads and stores alike.
    logic in_is_mem;
    logic in_unaligned;
    logic in_mis;

    always_comb begin
        in_unaligned = 1'b0;
        case (in_funct3[1:0])
            2'd0:    in_unaligned = 1'b0;
            2'd1:    in_unaligned = in_addr[0];
            2'd2:    in_unaligned = |in_addr[1:0];
            default: in_unaligned = |in_addr[2:0];
        endcase
    end

    assign in_is_mem = in_is_load | in_is_store;
    assign in_mis    = in_is_mem & in_unaligned;

    // Memory-side datapath, derived from the latched entry.
    logic [2:0]      offset;
    logic [5:0]      shamt;
    logic [XLEN-1:0] shifted;
    logic [XLEN-1:0] load_ext;
    logic [7:0]      size_mask;

    assign offset  = addr_q[2:0];
    assign shamt   = {offset, 3'b000};
    assign shifted = mem_rdata >> shamt;

    always_comb begin
        load_ext = shifted;
        case (funct3_q)
            3'b000:  load_ext = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            3'b001:  load_ext = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b010:  load_ext = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            3'b100:  load_ext = {{(XLEN-8){1'b0}},         shifted[7:0]};
            3'b101:  load_ext = {{(XLEN-16){1'b0}},        shifted[15:0]};
            3'b110:  load_ext = {{(XLEN-32){1'b0}},        shifted[31:0]};
            default: load_ext = shifted;  // 011 LD, and 111 also treated as LD
        endcase
    end

    always_comb begin
        size_mask = 8'hFF;
        case (funct3_q[1:0])
            2'd0:    size_mask = 8'h01;
            2'd1:    size_mask = 8'h03;
            2'd2:    size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
    end

    assign mem_raddr    = {addr_q[XLEN-1:3], 3'b000};
    assign mem_waddr    = {addr_q[XLEN-1:3], 3'b000};
    assign mem_wmask    = size_mask << offset;
    assign mem_wdata    = wdata_q << shamt;
    // Enables decode straight from the state register, so an asynchronous reset drops them at once.
    assign mem_read_en  = (state_q == ACCESS) && load_q;
    assign mem_write_en = (state_q == ACCESS) && store_q;

    assign in_ready     = (state_q == IDLE);
    assign out_valid    = (state_q == DONE);
    assign out_result   = out_result_q;
    assign out_rd       = out_rd_q;
    assign out_rd_wen   = out_rd_wen_q;
    assign out_misalign = out_misalign_q;

    always_comb begin
        state_d        = state_q;
        load_d         = load_q;
        store_d        = store_q;
        funct3_d       = funct3_q;
        addr_d         = addr_q;
        wdata_d        = wdata_q;
        rd_d           = rd_q;
        rd_wen_d       = rd_wen_q;
        out_result_d   = out_result_q;
        out_rd_d       = out_rd_q;
        out_rd_wen_d   = out_rd_wen_q;
        out_misalign_d = out_misalign_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load_d   = in_is_load;
                    store_d  = in_is_store & ~in_is_load;  // load wins when both are set
                    funct3_d = in_funct3;
                    addr_d   = in_addr;
                    wdata_d  = in_wdata;
                    rd_d     = in_rd;
                    rd_wen_d = in_rd_wen;
                    if (in_is_mem && !in_mis) begin
                        state_d = ACCESS;
                    end else begin
                        state_d        = DONE;
                        out_result_d   = in_addr;
                        out_rd_d       = in_rd;
                        out_rd_wen_d   = in_rd_wen & ~in_mis;
                        out_misalign_d = in_mis;
                    end
                end
            end
            ACCESS: begin
                state_d        = DONE;
                out_rd_d       = rd_q;
                out_misalign_d = 1'b0;
                if (load_q) begin
                    out_result_d = load_ext;
                    out_rd_wen_d = rd_wen_q;
                end else begin
                    out_result_d = '0;
                    out_rd_wen_d = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            load_q         <= 1'b0;
            store_q        <= 1'b0;
            funct3_q       <= '0;
            addr_q         <= '0;
            wdata_q        <= '0;
            rd_q           <= '0;
            rd_wen_q       <= 1'b0;
            out_result_q   <= '0;
            out_rd_q       <= '0;
            out_rd_wen_q   <= 1'b0;
            out_misalign_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            load_q         <= load_d;
            store_q        <= store_d;
            funct3_q       <= funct3_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            rd_q           <= rd_d;
            rd_wen_q       <= rd_wen_d;
            out_result_q   <= out_result_d;
            out_rd_q       <= out_rd_d;
            out_rd_wen_q   <= out_rd_wen_d;
            out_misalign_q <= out_misalign_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_stage.sv
module tb_lsu_mem_stage;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_is_load;
    logic        in_is_store;
    logic [2:0]  in_funct3;
    logic [63:0] in_addr;
    logic [63:0] in_wdata;
    logic [4:0]  in_rd;
    logic        in_rd_wen;
    logic [63:0] mem_raddr;
    logic        mem_read_en;
    logic [63:0] mem_waddr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_write_en;
    logic [63:0] mem_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [4:0]  out_rd;
    logic        out_rd_wen;
    logic        out_misalign;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Scoreboard: one entry per accepted instruction, popped when WB takes it.
    logic [63:0] exp_q[$];
    logic        exp_wen_q[$];
    logic        exp_mis_q[$];
    logic [4:0]  exp_rd_q[$];

    lsu_mem_stage #(.XLEN(64), .RD_W(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_is_load  (in_is_load),
        .in_is_store (in_is_store),
        .in_funct3   (in_funct3),
        .in_addr     (in_addr),
        .in_wdata    (in_wdata),
        .in_rd       (in_rd),
        .in_rd_wen   (in_rd_wen),
        .mem_raddr   (mem_raddr),
        .mem_read_en (mem_read_en),
        .mem_waddr   (mem_waddr),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask),
        .mem_write_en(mem_write_en),
        .mem_rdata   (mem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_rd      (out_rd),
        .out_rd_wen  (out_rd_wen),
        .out_misalign(out_misalign)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic logic [63:0] model_load(input logic [2:0] f3, input logic [63:0] rdata,
                                               input logic [2:0] off);
        logic [63:0] v;
        v = rdata >> (int'(off) * 8);
        case (f3)
            3'd0:    return 64'($signed(v[7:0]));
            3'd1:    return 64'($signed(v[15:0]));
            3'd2:    return 64'($signed(v[31:0]));
            3'd4:    return {56'd0, v[7:0]};
            3'd5:    return {48'd0, v[15:0]};
            3'd6:    return {32'd0, v[31:0]};
            default: return v;
        endcase
    endfunction

    function automatic logic model_mis(input logic [1:0] sz, input logic [2:0] off);
        int nb;
        nb = 1 << sz;
        return (int'(off) % nb) != 0;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic drive_entry(input logic ld, input logic st, input logic [2:0] f3,
                               input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [4:0] rd, input logic wen);
        in_valid    = 1'b1;
        in_is_load  = ld;
        in_is_store = st;
        in_funct3   = f3;
        in_addr     = addr;
        in_wdata    = wdata;
        in_rd       = rd;
        in_rd_wen   = wen;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drive_entry(1'b0, 1'b0, 3'd0, 64'd0, 64'd0, 5'd0, 1'b0);
        in_valid  = 1'b0;
        mem_rdata = 64'd0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || mem_read_en !== 1'b0 || mem_write_en !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: got valid=%b ren=%b wen=%b ready=%b, required 0 0 0 1",
                     out_valid, mem_read_en, mem_write_en, in_ready);
        end
        checks++;
        if (out_result !== 64'd0 || out_rd_wen !== 1'b0 || out_misalign !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got result=%h rd_wen=%b mis=%b, required 0 0 0",
                     out_result, out_rd_wen, out_misalign);
        end
    endtask

    // One aligned access: checks the single memory cycle, the 2-cycle latency and the WB entry.
    task automatic test_access(input string name, input logic ld, input logic st, input logic [2:0] f3,
                               input logic [63:0] addr, input logic [63:0] wdata, input logic [63:0] rdata,
                               input logic [63:0] exp_result, input logic exp_wen,
                               input logic [7:0] exp_mask, input logic [63:0] exp_wdata);
        logic [63:0] er;
        logic        ew;
        logic        em;
        logic [4:0]  erd;
        logic [4:0]  rd;
        logic        is_store;
        rd       = 5'($urandom_range(1, 31));
        is_store = st & ~ld;
        @(negedge clock);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s ready_before: got %b, required 1", name, in_ready);
        end
        drive_entry(ld, st, f3, addr, wdata, rd, 1'b1);
        mem_rdata = rdata;
        exp_q.push_back(exp_result);
        exp_wen_q.push_back(exp_wen);
        exp_mis_q.push_back(1'b0);
        exp_rd_q.push_back(rd);
        @(negedge clock);
        in_valid = 1'b0;
        checks++;
        if (mem_read_en !== ld || mem_write_en !== is_store || in_ready !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s access_en: got ren=%b wen=%b ready=%b valid=%b, required %b %b 0 0",
                     name, mem_read_en, mem_write_en, in_ready, out_valid, ld, is_store);
        end
        checks++;
        if (mem_raddr !== {addr[63:3], 3'b000} || mem_waddr !== {addr[63:3], 3'b000}) begin
            failures++;
            $display("FAIL %s access_addr: got raddr=%h waddr=%h, required %h", name, mem_raddr,
                     mem_waddr, {addr[63:3], 3'b000});
        end
        if (is_store) begin
            checks++;
            if (mem_wmask !== exp_mask || mem_wdata !== exp_wdata) begin
                failures++;
                $display("FAIL %s store_data: got mask=%h wdata=%h, required mask=%h wdata=%h",
                         name, mem_wmask, mem_wdata, exp_mask, exp_wdata);
            end
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b1 || mem_read_en !== 1'b0 || mem_write_en !== 1'b0) begin
            failures++;
            $display("FAIL %s latency: got valid=%b ren=%b wen=%b two cycles after accept, required 1 0 0",
                     name, out_valid, mem_read_en, mem_write_en);
        end
        er  = exp_q.pop_front();
        ew  = exp_wen_q.pop_front();
        em  = exp_mis_q.pop_front();
        erd = exp_rd_q.pop_front();
        checks++;
        if (out_result !== er || out_rd_wen !== ew || out_misalign !== em || out_rd !== erd) begin
            failures++;
            $display("FAIL %s result: got result=%h rd_wen=%b mis=%b rd=%0d, required %h %b %b %0d",
                     name, out_result, out_rd_wen, out_misalign, out_rd, er, ew, em, erd);
        end
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s release: got valid=%b ready=%b, required 0 1", name, out_valid, in_ready);
        end
    endtask

    task automatic test_loads();
        test_access("lb",  1, 0, 3'd0, 64'h8000_0003, 64'd0, 64'h1122_3344_80FF_EEDD,
                    64'hFFFF_FFFF_FFFF_FF80, 1'b1, 8'h00, 64'd0);
        test_access("lbu", 1, 0, 3'd4, 64'h8000_0003, 64'd0, 64'h1122_3344_80FF_EEDD,
                    64'h0000_0000_0000_0080, 1'b1, 8'h00, 64'd0);
        test_access("lh",  1, 0, 3'd1, 64'h8000_0002, 64'd0, 64'h1122_3344_80FF_EEDD,
                    64'hFFFF_FFFF_FFFF_80FF, 1'b1, 8'h00, 64'd0);
        test_access("lhu", 1, 0, 3'd5, 64'h8000_0002, 64'd0, 64'h1122_3344_80FF_EEDD,
                    64'h0000_0000_0000_80FF, 1'b1, 8'h00, 64'd0);
        test_access("lw",  1, 0, 3'd2, 64'h8000_0004, 64'd0, 64'h8899_AABB_0000_0000,
                    64'hFFFF_FFFF_8899_AABB, 1'b1, 8'h00, 64'd0);
        test_access("lwu", 1, 0, 3'd6, 64'h8000_0004, 64'd0, 64'h8899_AABB_0000_0000,
                    64'h0000_0000_8899_AABB, 1'b1, 8'h00, 64'd0);
        test_access("ld",  1, 0, 3'd3, 64'h8000_0008, 64'd0, 64'hF0E1_D2C3_B4A5_9687,
                    64'hF0E1_D2C3_B4A5_9687, 1'b1, 8'h00, 64'd0);
        test_access("f3_111_as_ld", 1, 0, 3'd7, 64'h8000_0010, 64'd0, 64'h8123_4567_89AB_CDEF,
                    64'h8123_4567_89AB_CDEF, 1'b1, 8'h00, 64'd0);
        test_access("load_and_store", 1, 1, 3'd3, 64'h8000_0018, 64'hFFFF, 64'h0000_0000_0000_1357,
                    64'h0000_0000_0000_1357, 1'b1, 8'h00, 64'd0);
    endtask

    task automatic test_stores();
        test_access("sh", 0, 1, 3'd1, 64'h8000_0006, 64'h1234, 64'hFFFF_FFFF_FFFF_FFFF,
                    64'd0, 1'b0, 8'hC0, 64'h1234_0000_0000_0000);
        test_access("sb", 0, 1, 3'd0, 64'h8000_0005, 64'hAB, 64'd0,
                    64'd0, 1'b0, 8'h20, 64'h0000_AB00_0000_0000);
        test_access("sw", 0, 1, 3'd2, 64'h8000_0004, 64'hCAFE_BABE, 64'd0,
                    64'd0, 1'b0, 8'hF0, 64'hCAFE_BABE_0000_0000);
        test_access("sd", 0, 1, 3'd3, 64'h8000_0020, 64'h0102_0304_0506_0708, 64'd0,
                    64'd0, 1'b0, 8'hFF, 64'h0102_0304_0506_0708);
    endtask

    task automatic test_misalign();
        logic [63:0] addrs[2];
        logic        lds[2];
        logic [2:0]  f3s[2];
        addrs[0] = 64'h8000_0002; lds[0] = 1'b1; f3s[0] = 3'd2;   // LW
        addrs[1] = 64'h8000_0004; lds[1] = 1'b0; f3s[1] = 3'd3;   // SD
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            drive_entry(lds[i], ~lds[i], f3s[i], addrs[i], 64'h55, 5'd7, 1'b1);
            exp_q.push_back(addrs[i]);
            exp_mis_q.push_back(1'b1);
            @(negedge clock);
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b1 || mem_read_en !== 1'b0 || mem_write_en !== 1'b0) begin
                failures++;
                $display("FAIL misalign%0d timing: got valid=%b ren=%b wen=%b, required 1 0 0",
                         i, out_valid, mem_read_en, mem_write_en);
            end
            checks++;
            if (out_misalign !== exp_mis_q.pop_front() || out_rd_wen !== 1'b0 || out_result !== exp_q.pop_front()) begin
                failures++;
                $display("FAIL misalign%0d result: got mis=%b rd_wen=%b result=%h, required 1 0 %h",
                         i, out_misalign, out_rd_wen, out_result, addrs[i]);
            end
            @(negedge clock);
        end
    endtask

    task automatic test_stall();
        @(negedge clock);
        out_ready = 1'b0;
        drive_entry(1'b0, 1'b0, 3'd0, 64'hDEAD, 64'd0, 5'd3, 1'b1);
        @(negedge clock);
        // A different entry waits upstream; it must not be taken while WB stalls.
        drive_entry(1'b1, 1'b0, 3'd3, 64'h8000_0040, 64'd0, 5'd9, 1'b1);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (out_valid !== 1'b1 || out_result !== 64'hDEAD || in_ready !== 1'b0 ||
                mem_read_en !== 1'b0 || out_rd !== 5'd3 || out_rd_wen !== 1'b1) begin
                failures++;
                $display("FAIL stall_cycle%0d: got valid=%b result=%h ready=%b ren=%b rd=%0d, required 1 dead 0 0 3",
                         i, out_valid, out_result, in_ready, mem_read_en, out_rd);
            end
            if (i < 4) @(negedge clock);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        @(negedge clock);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL stall_release: got valid=%b ready=%b, required 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clock);
        drive_entry(1'b1, 1'b0, 3'd3, 64'h8000_0008, 64'd0, 5'd4, 1'b1);
        mem_rdata = 64'h1111_2222_3333_4444;
        @(negedge clock);
        in_valid = 1'b0;
        checks++;
        if (mem_read_en !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid pre: got ren=%b, required 1", mem_read_en);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (mem_read_en !== 1'b0 || mem_write_en !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_mid async: got ren=%b wen=%b valid=%b ready=%b, required 0 0 0 1",
                     mem_read_en, mem_write_en, out_valid, in_ready);
        end
        @(negedge clock);
        reset = 1'b0;
        repeat (2) begin
            @(negedge clock);
            checks++;
            if (out_valid !== 1'b0 || in_ready !== 1'b1 || mem_read_en !== 1'b0 ||
                mem_write_en !== 1'b0 || out_result !== 64'd0) begin
                failures++;
                $display("FAIL rst_mid after: got valid=%b ready=%b ren=%b wen=%b result=%h, required 0 1 0 0 0",
                         out_valid, in_ready, mem_read_en, mem_write_en, out_result);
            end
        end
    endtask

    // Continuous upstream traffic: checks issue interval and every WB entry against the model.
    task automatic test_back_to_back();
        int          prev_cyc;
        int          prev_int;
        int          accepted;
        int          drain;
        logic [63:0] er;
        logic [4:0]  erd;
        logic        ew;
        logic        em;
        int          kind;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] rdata;
        logic [4:0]  rd;
        logic        wen;
        logic        mis;
        prev_cyc  = -1;
        prev_int  = 0;
        accepted  = 0;
        out_ready = 1'b1;
        in_valid  = 1'b0;
        for (int c = 0; c < 200 && accepted < 40; c++) begin
            @(negedge clock);
            if (out_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL b2b unexpected_out: got result=%h, required no entry", out_result);
                end else begin
                    er = exp_q.pop_front(); ew = exp_wen_q.pop_front();
                    em = exp_mis_q.pop_front(); erd = exp_rd_q.pop_front();
                    if (out_result !== er || out_rd_wen !== ew || out_misalign !== em || out_rd !== erd) begin
                        failures++;
                        $display("FAIL b2b result: got result=%h rd_wen=%b mis=%b rd=%0d, required %h %b %b %0d",
                                 out_result, out_rd_wen, out_misalign, out_rd, er, ew, em, erd);
                    end
                end
            end
            if (in_ready === 1'b1) begin
                if (prev_cyc >= 0) begin
                    checks++;
                    if (cyc - prev_cyc !== prev_int) begin
                        failures++;
                        $display("FAIL b2b interval: got %0d cycles, required %0d", cyc - prev_cyc, prev_int);
                    end
                end
                kind  = $urandom_range(0, 3);
                ld    = (kind == 0) || (kind == 3);
                st    = (kind == 1) || (kind == 3);
                f3    = ld ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 3));
                addr  = {32'h0, 32'($urandom)};
                if ($urandom_range(0, 3) != 0) addr[2:0] = addr[2:0] & ~3'((1 << f3[1:0]) - 1);
                rdata = {32'($urandom), 32'($urandom)};
                rd    = 5'($urandom_range(0, 31));
                wen   = 1'($urandom_range(0, 1));
                mis   = (ld || st) && model_mis(f3[1:0], addr[2:0]);
                drive_entry(ld, st, f3, addr, {32'($urandom), 32'($urandom)}, rd, wen);
                mem_rdata = rdata;
                if (!(ld || st) || mis) begin
                    exp_q.push_back(addr); exp_wen_q.push_back(wen & ~mis); exp_mis_q.push_back(mis);
                    prev_int = 2;
                end else if (ld) begin
                    exp_q.push_back(model_load(f3, rdata, addr[2:0])); exp_wen_q.push_back(wen);
                    exp_mis_q.push_back(1'b0);
                    prev_int = 3;
                end else begin
                    exp_q.push_back(64'd0); exp_wen_q.push_back(1'b0); exp_mis_q.push_back(1'b0);
                    prev_int = 3;
                end
                exp_rd_q.push_back(rd);
                prev_cyc = cyc;
                accepted++;
            end
        end
        // Drain: the in-flight entry must appear within a few cycles.
        drain = 0;
        while (exp_q.size() != 0 && drain < 6) begin
            @(negedge clock);
            in_valid = 1'b0;
            drain++;
            if (out_valid === 1'b1) begin
                checks++;
                er = exp_q.pop_front(); ew = exp_wen_q.pop_front();
                em = exp_mis_q.pop_front(); erd = exp_rd_q.pop_front();
                if (out_result !== er || out_rd_wen !== ew || out_misalign !== em || out_rd !== erd) begin
                    failures++;
                    $display("FAIL b2b drain_result: got result=%h rd_wen=%b mis=%b rd=%0d, required %h %b %b %0d",
                             out_result, out_rd_wen, out_misalign, out_rd, er, ew, em, erd);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if (exp_q.size() != 0 || accepted < 40) begin
            failures++;
            $display("FAIL b2b completion: got pending=%0d accepted=%0d, required pending=0 accepted=40",
                     exp_q.size(), accepted);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_loads();
        test_stores();
        test_misalign();
        test_stall();
        test_reset_mid_access();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
